// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the 5-stage MIPS pipeline.
// Latency: MULT/MULTU(/MADD*) hold busy for MULT_CYCLES, DIV/DIVU for DIV_CYCLES; MTHI/MTLO complete in one edge.
// Backpressure: start is accepted only while busy=0; requests made while busy are dropped (the hazard unit stalls them).
//
// Ports:
//   clk    - clock, all state updates on posedge
//   reset  - synchronous active-high reset (clears HI/LO, drops any in-flight result)
//   start  - op/A/B valid this cycle
//   op     - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, others NOP
//   A, B   - rs / rt operands
//   busy   - operation in flight; HI/LO not yet updated
//   HI, LO - architectural HI/LO registers (direct register outputs)
//
// Build option: define MDU_MADD_EN to enable MADD/MADDU/MSUB (ops 7-9); otherwise they act as NOP.

module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

  // How the pending result is folded into {HI,LO} at completion.
  typedef enum logic [1:0] {
    ACC_SET  = 2'd0,  // {HI,LO} <= result
    ACC_ADD  = 2'd1,  // {HI,LO} <= {HI,LO} + result
    ACC_SUB  = 2'd2,  // {HI,LO} <= {HI,LO} - result
    ACC_NONE = 2'd3   // leave HI/LO untouched (divide by zero)
  } acc_t;

  logic [CW-1:0] cnt;
  logic [63:0]   res;
  acc_t          acc;

  // ---------------------------------------------------------------------------
  // Combinational datapath on the operands presented with start.
  // ---------------------------------------------------------------------------
  logic [63:0] a_sx, b_sx;
  logic [63:0] prod_s, prod_u;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  logic        div_zero;
  logic [31:0] divisor_u;
  logic [31:0] quo_u, rem_u;

  assign div_zero  = (B == 32'd0);
  // Substitute 1 for a zero divisor so the datapath never produces X; the
  // result is discarded by ACC_NONE anyway.
  assign divisor_u = div_zero ? 32'd1 : B;
  assign quo_u     = A / divisor_u;
  assign rem_u     = A % divisor_u;

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case:
  // |0x80000000| is 0x80000000 as unsigned, and negating it wraps back to itself.
  logic [31:0] abs_a, abs_b, abs_b_nz;
  logic [31:0] quo_mag, rem_mag;
  logic [31:0] quo_s, rem_s;
  logic        quo_neg;

  assign abs_a    = A[31] ? (~A + 32'd1) : A;
  assign abs_b    = B[31] ? (~B + 32'd1) : B;
  assign abs_b_nz = div_zero ? 32'd1 : abs_b;
  assign quo_mag  = abs_a / abs_b_nz;
  assign rem_mag  = abs_a % abs_b_nz;
  assign quo_neg  = A[31] ^ B[31];
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo_s    = quo_neg ? (~quo_mag + 32'd1) : quo_mag;
  assign rem_s    = A[31]   ? (~rem_mag + 32'd1) : rem_mag;

  // ---------------------------------------------------------------------------
  // Control and architectural state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      HI   <= 32'd0;
      LO   <= 32'd0;
      busy <= 1'b0;
      cnt  <= '0;
      res  <= 64'd0;
      acc  <= ACC_NONE;
    end else if (busy) begin
      // Any start seen here is dropped; the counter only runs down.
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        busy <= 1'b0;
        case (acc)
          ACC_SET: {HI, LO} <= res;
          ACC_ADD: {HI, LO} <= {HI, LO} + res;
          ACC_SUB: {HI, LO} <= {HI, LO} - res;
          default: ;
        endcase
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          res  <= prod_s;
          acc  <= ACC_SET;
          cnt  <= MULT_LOAD;
          busy <= 1'b1;
        end
        OP_MULTU: begin
          res  <= prod_u;
          acc  <= ACC_SET;
          cnt  <= MULT_LOAD;
          busy <= 1'b1;
        end
        OP_DIV: begin
          res  <= {rem_s, quo_s};
          acc  <= div_zero ? ACC_NONE : ACC_SET;
          cnt  <= DIV_LOAD;
          busy <= 1'b1;
        end
        OP_DIVU: begin
          res  <= {rem_u, quo_u};
          acc  <= div_zero ? ACC_NONE : ACC_SET;
          cnt  <= DIV_LOAD;
          busy <= 1'b1;
        end
        OP_MTHI: HI <= A;
        OP_MTLO: LO <= A;
`ifdef MDU_MADD_EN
        // Accumulation reads {HI,LO} at completion; HI/LO cannot change
        // while busy, so that is also the value seen at issue.
        OP_MADD: begin
          res  <= prod_s;
          acc  <= ACC_ADD;
          cnt  <= MULT_LOAD;
          busy <= 1'b1;
        end
        OP_MADDU: begin
          res  <= prod_u;
          acc  <= ACC_ADD;
          cnt  <= MULT_LOAD;
          busy <= 1'b1;
        end
        OP_MSUB: begin
          res  <= prod_s;
          acc  <= ACC_SUB;
          cnt  <= MULT_LOAD;
          busy <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests  = 0;
  int failed = 0;
  int n;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op for a single edge, then count cycles with busy high
  // (sampled on negedges), bounded so a stuck busy cannot hang the run.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int ncyc);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    ncyc = 0;
    while (busy && ncyc < 100) begin
      ncyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi",   HI, 32'h0);
    check("reset_lo",   LO, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);

    // MULT -3 * 5 = -15
    run_op(4'd1, 32'hFFFFFFFD, 32'd5, n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFF1);

    // MULTU 0xFFFFFFFD * 5 = 0x4_FFFFFFF1
    run_op(4'd2, 32'hFFFFFFFD, 32'd5, n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", HI, 32'h00000004);
    check("multu_lo", LO, 32'hFFFFFFF1);

    // DIV -7 / 2 = -3 rem -1
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    check("div_cycles", n, 32'd10);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    // DIV overflow case: 0x80000000 / -1
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    check("divovf_lo", LO, 32'h80000000);
    check("divovf_hi", HI, 32'h00000000);

    // DIV 7 / -2 = -3 rem 1 (remainder follows dividend)
    run_op(4'd3, 32'd7, 32'hFFFFFFFE, n);
    check("divneg_lo", LO, 32'hFFFFFFFD);
    check("divneg_hi", HI, 32'h00000001);

    // DIVU 100 / 7 = 14 rem 2
    run_op(4'd4, 32'd100, 32'd7, n);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // MTHI / MTLO to 0x1234, then DIVU by zero leaves them alone
    run_op(4'd5, 32'h1234, 32'd0, n);
    check("mthi_cycles", n, 32'd0);
    check("mthi_hi", HI, 32'h1234);
    run_op(4'd6, 32'h1234, 32'd0, n);
    check("mtlo_lo", LO, 32'h1234);
    run_op(4'd4, 32'd7, 32'd0, n);
    check("divz_cycles", n, 32'd10);
    check("divz_hi", HI, 32'h1234);
    check("divz_lo", LO, 32'h1234);

    // MTHI issued while a MULT 6*7 is in flight must be dropped
    @(negedge clk);
    start = 1'b1; op = 4'd1; A = 32'd6; B = 32'd7;
    @(negedge clk);
    op = 4'd5; A = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    check("busy_mthi_hi_hold", HI, 32'h1234);
    check("busy_mthi_busy", {31'd0, busy}, 32'h1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_mthi_rem_cycles", n, 32'd4);
    check("busy_mthi_hi", HI, 32'h0);
    check("busy_mthi_lo", LO, 32'd42);

    // MTLO while idle: one edge, busy stays low
    @(negedge clk);
    start = 1'b1; op = 4'd6; A = 32'h55;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    check("mtlo_idle_lo", LO, 32'h55);
    check("mtlo_idle_busy", {31'd0, busy}, 32'h0);

    // NOP and an undefined op change nothing
    run_op(4'd0, 32'h99, 32'h99, n);
    run_op(4'd15, 32'h77, 32'h3, n);
    check("nop_cycles", n, 32'd0);
    check("nop_hi", HI, 32'h0);
    check("nop_lo", LO, 32'h55);

    // Reset on the 3rd busy cycle of a DIV
    @(negedge clk);
    start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd3;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_busy_before", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_hi",   HI, 32'h0);
    check("rstmid_lo",   LO, 32'h0);
    check("rstmid_busy", {31'd0, busy}, 32'h0);
    repeat (15) @(negedge clk);
    check("rstmid_late_hi", HI, 32'h0);
    check("rstmid_late_lo", LO, 32'h0);
    check("rstmid_late_busy", {31'd0, busy}, 32'h0);

    // MADDU 1*1 onto {0, 0xFFFFFFFF}
    run_op(4'd5, 32'h0, 32'd0, n);
    run_op(4'd6, 32'hFFFFFFFF, 32'd0, n);
    run_op(4'd8, 32'd1, 32'd1, n);
`ifdef MDU_MADD_EN
    check("maddu_cycles", n, 32'd5);
    check("maddu_hi", HI, 32'h1);
    check("maddu_lo", LO, 32'h0);
    // MSUB 1*1 back off: {1,0} - 1 = {0, 0xFFFFFFFF}
    run_op(4'd9, 32'd1, 32'd1, n);
    check("msub_hi", HI, 32'h0);
    check("msub_lo", LO, 32'hFFFFFFFF);
`else
    check("maddu_cycles", n, 32'd0);
    check("maddu_hi", HI, 32'h0);
    check("maddu_lo", LO, 32'hFFFFFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, failed);
    $fatal(1, "watchdog expired");
  end

endmodule
